fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-source MEM/WB forwarding unit.
- Provides forwarding selects for NRD ID/EX source operands from both EX/MEM and MEM/WB, with EX/MEM taking priority.
- Detects load-use hazards and tracks multi-cycle (mul/div) destination registers in a countdown scoreboard that drives stall and bubble.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- RA_W, 5, register address width; the scoreboard has 2**RA_W entries.
- NRD, 2, number of source operands per instruction.
- LAT_W, 3, width of the multi-cycle latency field and of each scoreboard counter.
- PERF_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  NRD*RA_W  IF/ID source registers; operand i occupies bits [i*RA_W +: RA_W].
- id_rs_used  in  NRD  per-operand flag: IF/ID instruction actually reads the operand.
- ex_rs  in  NRD*RA_W  ID/EX source registers.
- idex_rd  in  RA_W  ID/EX destination register.
- idex_memread  in  1  ID/EX instruction is a load.
- exmem_rd  in  RA_W  EX/MEM destination register.
- exmem_regw  in  1  EX/MEM regwrite.
- memwb_rd  in  RA_W  MEM/WB destination register.
- memwb_regw  in  1  MEM/WB regwrite.
- mc_issue  in  1  ID is issuing a multi-cycle op this cycle.
- mc_rd  in  RA_W  multi-cycle op destination register.
- mc_lat  in  LAT_W  cycles until the multi-cycle result is in the register file.
- fwd_sel  out  NRD*2  per operand: 00 regfile, 01 MEM/WB, 10 EX/MEM; 11 is never driven.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control signals; always equals stall.
- mc_accept  out  1  mc_issue was accepted this cycle.
- sb_busy  out  2**RA_W  per-register scoreboard busy bit.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, active-high): all scoreboard counters = 0 and stall_cycles = 0. With counters at 0, sb_busy = 0 and stall contribution from the scoreboard is 0.
- fwd_sel (combinational, per operand i):
  - 10 if exmem_regw && exmem_rd != 0 && exmem_rd == ex_rs[i];
  - else 01 if memwb_regw && memwb_rd != 0 && memwb_rd == ex_rs[i];
  - else 00.
- Load-use (combinational): for any i with id_rs_used[i] && id_rs[i] != 0, hazard if idex_memread && idex_rd == id_rs[i].
- Scoreboard hazard (combinational): for any such i, hazard if sb_busy[id_rs[i]].
- stall = load-use OR scoreboard hazard. bubble = stall. Both are purely combinational; zero added latency.
- Scoreboard:
  - Counter cnt[r] of width LAT_W; sb_busy[r] = (cnt[r] != 0).
  - Each cycle, every nonzero cnt decrements by 1.
  - mc_accept = mc_issue && !stall && mc_rd != 0.
  - On mc_accept: cnt[mc_rd] <= max(mc_lat, 1). Issue overrides the decrement of that entry in the same cycle. Issue to an already-busy register overwrites its count (WAW: latest wins).
  - mc_issue while stalled or with mc_rd == 0: ignored, no state change.
  - cnt[0] is always 0.
- A register is readable from the register file in the cycle its cnt is 0. The register file is write-first. Multi-cycle results are never forwarded.
- stall_cycles increments by 1 on every cycle with stall = 1 and saturates at all-ones.
- Reset asserted mid-stall: stall drops as soon as the scoreboard clears, within the same cycle (asynchronous).

Test Plan:
- exmem_regw=1, exmem_rd=5, memwb_regw=1, memwb_rd=5, ex_rs[0]=5 -> fwd_sel[1:0]=10. With exmem_regw=0 -> 01.
- exmem_regw=1, exmem_rd=0, ex_rs[1]=0 -> fwd_sel[3:2]=00. Also ex_rs[1]=7 with no matching write -> 00.
- idex_memread=1, idex_rd=9, id_rs[1]=9, id_rs_used=2'b10 -> stall=bubble=1 for 1 cycle; stall_cycles 0->1. With id_rs_used=2'b01 -> stall=0.
- mc_issue, mc_rd=12, mc_lat=3 -> sb_busy[12]=1 for exactly 3 cycles. A dependent id_rs[0]=12 stalls 3 cycles, then proceeds with fwd_sel=00.
- mc_issue mc_rd=4 while load-use stall is active -> mc_accept=0 and sb_busy[4] stays 0. Re-issue with mc_lat=0 -> busy for 1 cycle.
- Hold stall=1 for 2**PERF_W+3 cycles -> stall_cycles stays at all-ones. Assert rst mid-count -> stall_cycles=0 and sb_busy=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and multi-cycle scoreboard for an in-order pipeline.
// Drives forwarding selects, stall/bubble, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned LAT_W  = 3,
    parameter int unsigned PERF_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*RA_W-1:0]   id_rs,
    input  logic [NRD-1:0]        id_rs_used,
    input  logic [NRD*RA_W-1:0]   ex_rs,
    input  logic [RA_W-1:0]       idex_rd,
    input  logic                  idex_memread,
    input  logic [RA_W-1:0]       exmem_rd,
    input  logic                  exmem_regw,
    input  logic [RA_W-1:0]       memwb_rd,
    input  logic                  memwb_regw,
    input  logic                  mc_issue,
    input  logic [RA_W-1:0]       mc_rd,
    input  logic [LAT_W-1:0]      mc_lat,
    output logic [NRD*2-1:0]      fwd_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic                  mc_accept,
    output logic [(2**RA_W)-1:0]  sb_busy,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int unsigned NREG = 2**RA_W;

    logic [NREG-1:0][LAT_W-1:0] cnt;
    logic                       load_use;
    logic                       sb_hazard;
    logic [LAT_W-1:0]           lat_eff;

    // Busy bit per register: a nonzero countdown means the result is not yet written back.
    always_comb begin
        sb_busy = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            sb_busy[r] = (cnt[r] != '0);
        end
    end

    // EX/MEM has priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_sel = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (exmem_regw && (exmem_rd != '0) && (exmem_rd == ex_rs[i*RA_W +: RA_W])) begin
                fwd_sel[i*2 +: 2] = 2'b10;
            end else if (memwb_regw && (memwb_rd != '0) && (memwb_rd == ex_rs[i*RA_W +: RA_W])) begin
                fwd_sel[i*2 +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        load_use  = 1'b0;
        sb_hazard = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (id_rs_used[i] && (id_rs[i*RA_W +: RA_W] != '0)) begin
                if (idex_memread && (idex_rd == id_rs[i*RA_W +: RA_W])) begin
                    load_use = 1'b1;
                end
                if (sb_busy[id_rs[i*RA_W +: RA_W]]) begin
                    sb_hazard = 1'b1;
                end
            end
        end
    end

    assign stall     = load_use | sb_hazard;
    assign bubble    = stall;
    assign mc_accept = mc_issue && !stall && (mc_rd != '0);
    // A zero latency still needs one cycle before the register file holds the result.
    assign lat_eff   = (mc_lat == '0) ? LAT_W'(1) : mc_lat;

    // Countdown scoreboard; a new issue overrides both the decrement and any older count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (mc_accept && (mc_rd == RA_W'(r))) begin
                    cnt[r] <= lat_eff;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
            cnt[0] <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed steps plus random traffic checked against
// a timestamp-based reference model of the scoreboard and forwarding rules.
module tb_fwd_hazard_unit;

    localparam int unsigned RA_W   = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned PERF_W = 16;
    localparam int unsigned NREG   = 2**RA_W;
    localparam longint      PMAX   = (64'd1 << PERF_W) - 1;

    logic                 clk;
    logic                 rst;
    logic [NRD*RA_W-1:0]  id_rs;
    logic [NRD-1:0]       id_rs_used;
    logic [NRD*RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]      idex_rd;
    logic                 idex_memread;
    logic [RA_W-1:0]      exmem_rd;
    logic                 exmem_regw;
    logic [RA_W-1:0]      memwb_rd;
    logic                 memwb_regw;
    logic                 mc_issue;
    logic [RA_W-1:0]      mc_rd;
    logic [LAT_W-1:0]     mc_lat;
    logic [NRD*2-1:0]     fwd_sel;
    logic                 stall;
    logic                 bubble;
    logic                 mc_accept;
    logic [NREG-1:0]      sb_busy;
    logic [PERF_W-1:0]    stall_cycles;

    fwd_hazard_unit #(.RA_W(RA_W), .NRD(NRD), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_rd(exmem_rd),
        .exmem_regw(exmem_regw), .memwb_rd(memwb_rd), .memwb_regw(memwb_regw),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .fwd_sel(fwd_sel),
        .stall(stall), .bubble(bubble), .mc_accept(mc_accept), .sb_busy(sb_busy),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint ready [NREG];
    longint perf  = 0;

    // Reference model: register r is busy while the current cycle precedes its ready time.
    function automatic bit m_busy(int r);
        return (r != 0) && (ready[r] > cyc);
    endfunction

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic bit m_stall();
        bit s;
        int r;
        s = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            r = int'(id_rs[i*RA_W +: RA_W]);
            if (id_rs_used[i] && r != 0) begin
                if (idex_memread && int'(idex_rd) == r) s = 1'b1;
                if (m_busy(r)) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic bit m_accept();
        return mc_issue && !m_stall() && (mc_rd != 0);
    endfunction

    function automatic logic [NRD*2-1:0] m_fwd();
        logic [NRD*2-1:0] f;
        int r;
        f = '0;
        for (int i = 0; i < NRD; i++) begin
            r = int'(ex_rs[i*RA_W +: RA_W]);
            if (exmem_regw && exmem_rd != 0 && int'(exmem_rd) == r)      f[i*2 +: 2] = 2'b10;
            else if (memwb_regw && memwb_rd != 0 && int'(memwb_rd) == r) f[i*2 +: 2] = 2'b01;
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_fwd"},    64'(fwd_sel),      64'(m_fwd()));
        chk({tag, "_stall"},  64'(stall),        64'(m_stall()));
        chk({tag, "_bubble"}, 64'(bubble),       64'(m_stall()));
        chk({tag, "_accept"}, 64'(mc_accept),    64'(m_accept()));
        chk({tag, "_busy"},   64'(sb_busy),      64'(m_busy_vec()));
        chk({tag, "_perf"},   64'(stall_cycles), 64'(perf));
    endtask

    // Advance one clock, applying the model's view of this cycle's stall and issue.
    task automatic tick();
        bit s, a;
        int lat;
        s = m_stall();
        a = m_accept();
        lat = (mc_lat == 0) ? 1 : int'(mc_lat);
        @(posedge clk);
        if (a) ready[mc_rd] = cyc + lat + 1;
        if (s && perf != PMAX) perf++;
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready[r] = 0;
        perf = 0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        id_rs = '0; id_rs_used = '0; ex_rs = '0; idex_rd = '0; idex_memread = 1'b0;
        exmem_rd = '0; exmem_regw = 1'b0; memwb_rd = '0; memwb_regw = 1'b0;
        mc_issue = 1'b0; mc_rd = '0; mc_lat = '0;
        #2;
        chk("rst_busy", 64'(sb_busy), 64'd0);
        chk("rst_perf", 64'(stall_cycles), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Forwarding priority.
        exmem_regw = 1'b1; exmem_rd = 5; memwb_regw = 1'b1; memwb_rd = 5;
        ex_rs = {RA_W'(0), RA_W'(5)};
        #1;
        chk("fwd0_exmem", 64'(fwd_sel[1:0]), 64'd2);
        check_all("fwd_a");
        tick();
        exmem_regw = 1'b0;
        #1;
        chk("fwd0_memwb", 64'(fwd_sel[1:0]), 64'd1);
        check_all("fwd_b");
        tick();

        // r0 and non-matching operands read the register file.
        exmem_regw = 1'b1; exmem_rd = 0; memwb_regw = 1'b0;
        ex_rs = {RA_W'(0), RA_W'(3)};
        #1;
        chk("fwd1_r0", 64'(fwd_sel[3:2]), 64'd0);
        check_all("fwd_c");
        tick();
        ex_rs = {RA_W'(7), RA_W'(3)};
        #1;
        chk("fwd1_nomatch", 64'(fwd_sel[3:2]), 64'd0);
        check_all("fwd_d");
        tick();

        // Load-use hazard on operand 1.
        exmem_regw = 1'b0;
        idex_memread = 1'b1; idex_rd = 9; id_rs = {RA_W'(9), RA_W'(3)}; id_rs_used = 2'b10;
        #1;
        chk("lu_stall", 64'(stall), 64'd1);
        chk("lu_bubble", 64'(bubble), 64'd1);
        chk("lu_perf0", 64'(stall_cycles), 64'd0);
        check_all("lu_a");
        tick();
        idex_memread = 1'b0;
        #1;
        chk("lu_perf1", 64'(stall_cycles), 64'd1);
        chk("lu_release", 64'(stall), 64'd0);
        idex_memread = 1'b1; id_rs_used = 2'b01;
        #1;
        chk("lu_unused", 64'(stall), 64'd0);
        check_all("lu_b");
        tick();

        // Multi-cycle op to r12 with latency 3.
        idex_memread = 1'b0; id_rs_used = 2'b00; ex_rs = '0;
        mc_issue = 1'b1; mc_rd = 12; mc_lat = 3;
        #1;
        chk("mc_accept", 64'(mc_accept), 64'd1);
        check_all("mc_a");
        tick();
        mc_issue = 1'b0;
        id_rs = {RA_W'(0), RA_W'(12)}; id_rs_used = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mc_busy12", 64'(sb_busy[12]), 64'd1);
            chk("mc_dep_stall", 64'(stall), 64'd1);
            check_all("mc_b");
            tick();
        end
        #1;
        chk("mc_free12", 64'(sb_busy[12]), 64'd0);
        chk("mc_dep_go", 64'(stall), 64'd0);
        chk("mc_dep_fwd", 64'(fwd_sel), 64'd0);
        check_all("mc_c");
        tick();

        // Issue blocked by a load-use stall, then zero-latency reissue.
        idex_memread = 1'b1; idex_rd = 9; id_rs = {RA_W'(9), RA_W'(0)}; id_rs_used = 2'b10;
        mc_issue = 1'b1; mc_rd = 4; mc_lat = 2;
        #1;
        chk("blk_accept", 64'(mc_accept), 64'd0);
        check_all("blk_a");
        tick();
        idex_memread = 1'b0; mc_lat = 0;
        #1;
        chk("blk_busy4", 64'(sb_busy[4]), 64'd0);
        chk("lat0_accept", 64'(mc_accept), 64'd1);
        check_all("blk_b");
        tick();
        mc_issue = 1'b0;
        #1;
        chk("lat0_busy", 64'(sb_busy[4]), 64'd1);
        tick();
        #1;
        chk("lat0_free", 64'(sb_busy[4]), 64'd0);
        check_all("blk_c");
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NRD; i++) begin
                id_rs[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 7));
                ex_rs[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 7));
            end
            id_rs_used   = NRD'($urandom);
            idex_rd      = RA_W'($urandom_range(0, 7));
            idex_memread = ($urandom_range(0, 3) == 0);
            exmem_rd     = RA_W'($urandom_range(0, 7));
            exmem_regw   = 1'($urandom);
            memwb_rd     = RA_W'($urandom_range(0, 7));
            memwb_regw   = 1'($urandom);
            mc_issue     = ($urandom_range(0, 2) == 0);
            mc_rd        = RA_W'($urandom_range(0, 7));
            mc_lat       = LAT_W'($urandom);
            #1;
            check_all("rnd");
            tick();
        end

        // Hold a load-use stall long enough to saturate the counter.
        mc_issue = 1'b0; exmem_regw = 1'b0; memwb_regw = 1'b0;
        idex_memread = 1'b1; idex_rd = 9; id_rs = {RA_W'(9), RA_W'(0)}; id_rs_used = 2'b10;
        for (longint n = 0; n < PMAX + 4; n++) tick();
        #1;
        chk("sat_perf", 64'(stall_cycles), 64'(PMAX));
        check_all("sat");
        tick();
        #1;
        chk("sat_hold", 64'(stall_cycles), 64'(PMAX));

        // Asynchronous reset while the scoreboard is stalling a dependent.
        idex_memread = 1'b0; id_rs_used = 2'b00;
        mc_issue = 1'b1; mc_rd = 20; mc_lat = 6;
        #1;
        tick();
        mc_issue = 1'b0;
        id_rs = {RA_W'(0), RA_W'(20)}; id_rs_used = 2'b01;
        #1;
        chk("arst_pre_stall", 64'(stall), 64'd1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_busy", 64'(sb_busy), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_perf", 64'(stall_cycles), 64'd0);
        check_all("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
